// File: rtl/gate_bist_pkg.sv
// Shared definitions for the two-input gates self-test: FSM states,
// bit positions of each gate output, and the golden response table.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } bist_state_t;

    // Bit position of each gate output on the 8-bit response bus
    localparam int AND_B  = 0;
    localparam int OR_B   = 1;
    localparam int NOTA_B = 2;
    localparam int NOTB_B = 3;
    localparam int NAND_B = 4;
    localparam int NOR_B  = 5;
    localparam int XOR_B  = 6;
    localparam int XNOR_B = 7;

    localparam int NUM_VEC = 4;
    localparam logic [1:0] LAST_VEC = 2'd3;

    // Expected gate responses indexed by vec = {a,b}
    localparam logic [7:0] GOLDEN [NUM_VEC] = '{8'hBC, 8'h56, 8'h5A, 8'h83};

endpackage

// File: rtl/gate_bist_expect.sv
// Combinational golden model of the gates block: derives the expected
// 8-bit response from the gate equations for the applied vector {a,b}.
module gate_bist_expect
    import gate_bist_pkg::*;
(
    input  logic [1:0] vec,
    output logic [7:0] expected
);

    logic a;
    logic b;

    assign a = vec[1];
    assign b = vec[0];

    // Evaluate every gate equation for the current vector
    always_comb begin
        expected         = '0;
        expected[AND_B]  = a & b;
        expected[OR_B]   = a | b;
        expected[NOTA_B] = ~a;
        expected[NOTB_B] = ~b;
        expected[NAND_B] = ~(a & b);
        expected[NOR_B]  = ~(a | b);
        expected[XOR_B]  = a ^ b;
        expected[XNOR_B] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_bist.sv
// Built-in self-test for the two-input gates block. Walks a/b through
// 00, 01, 10, 11, waits for each vector to settle, compares the gate
// outputs against the golden model and keeps error/first-failure results.
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 a_out,
    output logic                 b_out,
    input  logic [7:0]           gate_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [1:0]           fail_vec,
    output logic [7:0]           fail_mask
);

    // Settle counter only needs to reach SETTLE_CYCLES-1
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    bist_state_t      state_reg;
    logic [1:0]       vec_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [7:0] expected;
    logic [7:0] diff;
    logic       mismatch;
    logic       first_fail;
    logic [1:0] vec_next;

    gate_bist_expect u_expect (
        .vec      (vec_reg),
        .expected (expected)
    );

    // Response comparison; only consumed while in SAMPLE
    always_comb begin
        diff       = gate_in ^ expected;
        mismatch   = (diff != 8'h00);
        // err_count saturates at a nonzero value, so zero means "no failure yet"
        first_fail = mismatch && (err_count == '0);
        vec_next   = vec_reg + 2'd1;
    end

    // Sequencer: stimulus, settle timing, sampling and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            vec_reg   <= 2'd0;
            cnt_reg   <= '0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= 2'd0;
            fail_mask <= 8'h00;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= SETTLE;
                        vec_reg   <= 2'd0;
                        cnt_reg   <= '0;
                        a_out     <= 1'b0;
                        b_out     <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        fail_vec  <= 2'd0;
                        fail_mask <= 8'h00;
                    end
                end

                SETTLE: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= SAMPLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                SAMPLE: begin
                    if (mismatch && (err_count != ERR_MAX)) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (first_fail) begin
                        fail_vec  <= vec_reg;
                        fail_mask <= diff;
                    end
                    if (vec_reg == LAST_VEC) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (err_count == '0) && !mismatch;
                    end else begin
                        // Next vector is driven on the same edge that leaves SAMPLE
                        state_reg <= SETTLE;
                        vec_reg   <= vec_next;
                        a_out     <= vec_next[1];
                        b_out     <= vec_next[0];
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Hardware stimulus generator and response checker (built-in self-test) for the two-input digital gates block.
- Drives the gates block's a/b inputs exhaustively through all four vectors, in order 00, 01, 10, 11.
- After each vector settles, samples the eight gate outputs and compares them against a golden model.
- Reports pass/fail, an error count and the first-failure details. Sits beside the gates block inside the tt_um wrapper.

Parameters:
- SETTLE_CYCLES, 2: cycles in SETTLE after each vector is applied, before sampling. Must be >= 1.
- ERR_CNT_W, 3: width of err_count. Must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled run request; acted on only in IDLE or DONE.
- a_out  output  1  registered stimulus to the gates block input a.
- b_out  output  1  registered stimulus to the gates block input b.
- gate_in  input  8  gates block outputs. Bit order: [0]=and, [1]=or, [2]=not_a, [3]=not_b, [4]=nand, [5]=nor, [6]=xor, [7]=xnor.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  high in DONE; holds until the next accepted start or reset.
- pass  output  1  valid while done=1; 1 iff no vector mismatched.
- err_count  output  ERR_CNT_W  number of mismatching vectors, saturating.
- fail_vec  output  2  {a,b} of the first mismatching vector; 0 if none.
- fail_mask  output  8  gate_in XOR expected at the first mismatching vector; 0 if none.

Behaviour:
- Vector encoding: vec[1]=a, vec[0]=b; a_out=vec[1], b_out=vec[0].
- Golden values per vec (bit 7..0): 0 -> 0xBC, 1 -> 0x56, 2 -> 0x5A, 3 -> 0x83.
- Reset, asynchronous: state=IDLE, vec=0, settle counter=0, and every output = 0 (a_out, b_out, busy, done, pass, err_count, fail_vec, fail_mask).
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE with start=1 at an edge:
  - vec<=0, a_out/b_out<=0, cnt<=0.
  - err_count, fail_vec, fail_mask, pass, done all cleared.
  - state<=SETTLE.
- IDLE or DONE with start=0: hold all state.
- SETTLE: cnt increments each cycle. When cnt==SETTLE_CYCLES-1: cnt<=0, state<=SAMPLE.
- SAMPLE (one cycle): compare gate_in against golden(vec).
  - On mismatch: err_count increments, saturating at all-ones.
  - On the first mismatch only: capture fail_vec and fail_mask.
  - If vec==3: state<=DONE; pass<=(no mismatch in the whole run, including this sample); done<=1.
  - Else: vec<=vec+1, a/b updated on the same edge, state<=SETTLE.
- Timing: with edge 0 = the edge that accepts start, done=1 is visible after edge 4*(SETTLE_CYCLES+1). Example: 12 edges for the default SETTLE_CYCLES=2.
- start is ignored while busy.
- gate_in is sampled only in SAMPLE; values at other times are don't-care.
- Reset mid-run aborts immediately to the reset values above; no partial results are retained.
- a_out/b_out are stable for the whole SETTLE+SAMPLE window of each vector.

Decomposition:
- Shared package gate_bist_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - gate bit-index constants (AND_B=0 … XNOR_B=7);
  - the golden-vector constant array {0xBC, 0x56, 0x5A, 0x83}.
- One sub-module is natural: gate_bist_expect, a combinational golden model. Input vec[1:0]; output expected[7:0] computed from gate equations. It is cross-checked against the package constants in the bench.

Test Plan:
- Fault-free: real gates block connected, SETTLE_CYCLES=2, start pulse at edge 0. Required: a/b step through 00, 01, 10, 11; done=1 after edge 12; pass=1, err_count=0, fail_vec=0, fail_mask=0.
- xor stuck-at-0: force gate_in[6]=0. Required: vectors 1 and 2 mismatch; err_count=2, pass=0, fail_vec=2'b01, fail_mask=0x40.
- All outputs inverted, ERR_CNT_W=2. Required: 4 mismatches, err_count saturates at 3; fail_vec=0, fail_mask=0xFF, pass=0.
- start held high during SETTLE/SAMPLE of vector 1. Required: no restart, vector sequence unchanged, done still at edge 12. Start asserted in DONE then restarts: result registers cleared on the accepting edge, busy=1.
- rst asserted during SAMPLE of vector 2 of a failing run. Required: every output 0 asynchronously, state IDLE. A subsequent fault-free run gives pass=1, err_count=0.
